sol32_mem_arbiter: RTL and testbench

SOL32_MEM_ARBITER -- requirements
Module: sol32_mem_arbiter

---
 rtl/sol32_pkg.sv | 18 +
 rtl/sol32_ack_timer.sv | 30 +++
 rtl/sol32_mem_arbiter.sv | 117 +++++++++++
 tb/tb_sol32_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sol32_pkg.sv
// Shared types and constants for the sol32 memory arbiter: FSM states,
// access-width encodings and the default acknowledge timeout.
package sol32_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DATA  = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/sol32_ack_timer.sv
// Counts cycles a memory request waits for its acknowledge; expired is
// combinational and fires in the cycle the count would reach TIMEOUT.
module sol32_ack_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // Firing on the increment that lands on TIMEOUT keeps MemReq high for exactly TIMEOUT cycles.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/sol32_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data requesters.
// Grant to MemReq in one cycle; Valid one cycle after MemAck or timeout; DONE blocks re-arbitration.
module sol32_mem_arbiter
    import sol32_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        IfReq,
    input  logic [31:0] IfAddr,
    output logic [31:0] IfData,
    output logic        IfValid,
    input  logic        DReq,
    input  logic        DWrite,
    input  logic [1:0]  DWidth,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    output logic [31:0] DRData,
    output logic        DValid,
    output logic        BusError,
    output logic        Stall,
    output logic        MemReq,
    output logic        MemWrite,
    output logic [1:0]  MemWidth,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck
);

    state_t      state;
    logic        last_fetch;
    logic        grant_data;
    logic        grant_fetch;
    logic        timer_en;
    logic        expired;
    logic [31:0] rdata;

    // With both pending, data wins unless data was the last one served.
    assign grant_data  = (state == IDLE) && DReq && (!IfReq || last_fetch);
    assign grant_fetch = (state == IDLE) && IfReq && !grant_data;
    assign timer_en    = MemReq && !MemAck;

    assign Stall  = (IfReq | DReq) & ~(IfValid | DValid);
    assign IfData = rdata;
    assign DRData = rdata;

    sol32_ack_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_ack_timer (
        .clk    (Clock),
        .rst    (Reset),
        .clear  (grant_data || grant_fetch),
        .enable (timer_en),
        .expired(expired)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            last_fetch <= 1'b1;
            MemReq     <= 1'b0;
            MemWrite   <= 1'b0;
            MemWidth   <= '0;
            MemAddr    <= '0;
            MemWData   <= '0;
            IfValid    <= 1'b0;
            DValid     <= 1'b0;
            BusError   <= 1'b0;
            rdata      <= '0;
        end else begin
            IfValid  <= 1'b0;
            DValid   <= 1'b0;
            BusError <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state      <= DATA;
                        last_fetch <= 1'b0;
                        MemReq     <= 1'b1;
                        MemWrite   <= DWrite;
                        MemWidth   <= DWidth;
                        MemAddr    <= DAddr;
                        MemWData   <= DWData;
                    end else if (grant_fetch) begin
                        state      <= FETCH;
                        last_fetch <= 1'b1;
                        MemReq     <= 1'b1;
                        MemWrite   <= 1'b0;
                        MemWidth   <= WIDTH_WORD;
                        MemAddr    <= IfAddr;
                        MemWData   <= '0;
                    end
                end
                FETCH, DATA: begin
                    // An ack in the expiry cycle still counts as success.
                    if (MemAck || expired) begin
                        state    <= DONE;
                        MemReq   <= 1'b0;
                        IfValid  <= (state == FETCH);
                        DValid   <= (state == DATA);
                        BusError <= !MemAck;
                        rdata    <= (MemAck && !MemWrite) ? MemRData : '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sol32_mem_arbiter.sv
// Randomized scoreboard bench for sol32_mem_arbiter; memory latency and timeouts
// are encoded in address bits [6:4] so expectations follow from the request alone.
module tb_sol32_mem_arbiter;

    localparam int TO = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [1:0]  width;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        store;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        IfReq = 1'b0;
    logic [31:0] IfAddr = '0;
    logic [31:0] IfData;
    logic        IfValid;
    logic        DReq = 1'b0;
    logic        DWrite = 1'b0;
    logic [1:0]  DWidth = '0;
    logic [31:0] DAddr = '0;
    logic [31:0] DWData = '0;
    logic [31:0] DRData;
    logic        DValid;
    logic        BusError;
    logic        Stall;
    logic        MemReq;
    logic        MemWrite;
    logic [1:0]  MemWidth;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData = '0;
    logic        MemAck = 1'b0;

    sol32_mem_arbiter #(.TIMEOUT(TO)) dut (
        .Clock(Clock), .Reset(Reset),
        .IfReq(IfReq), .IfAddr(IfAddr), .IfData(IfData), .IfValid(IfValid),
        .DReq(DReq), .DWrite(DWrite), .DWidth(DWidth), .DAddr(DAddr),
        .DWData(DWData), .DRData(DRData), .DValid(DValid),
        .BusError(BusError), .Stall(Stall),
        .MemReq(MemReq), .MemWrite(MemWrite), .MemWidth(MemWidth),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck)
    );

    always #5 Clock = ~Clock;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_if[$];
    exp_t exp_d[$];
    cmd_t f_cmd = '0;
    cmd_t d_cmd = '0;
    int   n_issued = 0;
    int   mem_bursts = 0;

    bit          force_on = 1'b0;
    int          force_delay = 0;
    logic [31:0] force_rdata = '0;

    function automatic logic [31:0] memfunc(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", nm, $time);
    endtask

    // Memory: ack after MemAddr[5:4] extra cycles, never if MemAddr[6]; stray acks while idle.
    initial begin : memory
        int mcyc;
        int dly;
        bit noack;
        mcyc = 0;
        forever begin
            @(posedge Clock);
            #1;
            if (MemReq && !Reset) begin
                dly    = force_on ? force_delay : int'(MemAddr[5:4]);
                noack  = !force_on && MemAddr[6];
                MemAck = !noack && (mcyc == dly);
                MemRData = MemAck ? (force_on ? force_rdata : memfunc(MemAddr)) : $urandom;
                mcyc++;
            end else begin
                mcyc     = 0;
                MemAck   = ($urandom_range(0, 3) == 0);
                MemRData = $urandom;
            end
        end
    end

    // Monitor: grant order, command stability, burst length, Valid placement, scoreboard pops.
    initial begin : monitor
        bit   prev_mr, prev_if, prev_d, last_fetch, owner_d;
        int   len, explen, gap;
        cmd_t cmd;
        exp_t e;
        prev_mr = 0; prev_if = 0; prev_d = 0; last_fetch = 1; owner_d = 0;
        len = 0; explen = 0; gap = 2; cmd = '0;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                prev_mr = 0; prev_if = 0; prev_d = 0; last_fetch = 1; gap = 2;
            end else begin
                chk("stall", Stall, (IfReq | DReq) & ~(IfValid | DValid));
                if (IfValid && DValid) fail("both_valid");
                if (MemReq && !prev_mr) begin
                    if (!prev_if && !prev_d) fail("memreq_without_request");
                    owner_d    = (prev_if && prev_d) ? last_fetch : prev_d;
                    last_fetch = !owner_d;
                    cmd        = owner_d ? d_cmd : f_cmd;
                    chk("rearb_gap", gap >= 2, 1);
                    len = 1;
                    if (force_on) explen = force_delay + 1;
                    else if (cmd.addr[6]) explen = TO;
                    else explen = int'(cmd.addr[5:4]) + 1;
                    mem_bursts++;
                end else if (MemReq) begin
                    len++;
                end
                if (MemReq)
                    chk(owner_d ? "dcmd" : "fcmd",
                        {MemAddr, MemWrite, MemWidth, owner_d ? MemWData : 32'h0}, cmd);
                if (!MemReq && prev_mr) begin
                    chk("memreq_len", len, explen);
                    chk("valid_owner", {IfValid, DValid}, owner_d ? 2'b01 : 2'b10);
                    gap = 1;
                end else begin
                    chk("valid_spurious", IfValid | DValid, 0);
                    if (!MemReq) gap++;
                end
                if (!IfValid && !DValid) chk("buserr_idle", BusError, 0);
                if (IfValid) begin
                    if (exp_if.size() == 0) fail("ifvalid_unexpected");
                    else begin
                        e = exp_if.pop_front();
                        chk("ifdata", IfData, e.data);
                        chk("if_buserr", BusError, e.err);
                    end
                end
                if (DValid) begin
                    if (exp_d.size() == 0) fail("dvalid_unexpected");
                    else begin
                        e = exp_d.pop_front();
                        if (e.err || !e.store) chk("drdata", DRData, e.data);
                        chk("d_buserr", BusError, e.err);
                    end
                end
                prev_mr = MemReq; prev_if = IfReq; prev_d = DReq;
            end
        end
    end

    task automatic drive_fetch(input int n);
        logic [31:0] a;
        bit ok;
        for (int i = 0; i < n; i++) begin
            int gap = (i == 0) ? 0 : $urandom_range(0, 2);
            if (gap > 0) begin
                IfReq = 1'b0;
                repeat (gap) @(posedge Clock);
                #1;
            end
            a = $urandom; a[31] = 1'b0; a[6] = ($urandom_range(0, 7) == 0); a[1:0] = 2'b00;
            f_cmd = '{addr: a, write: 1'b0, width: 2'b10, wdata: 32'h0};
            exp_if.push_back('{data: a[6] ? 32'h0 : memfunc(a), err: a[6], store: 1'b0});
            IfAddr = a; IfReq = 1'b1; n_issued++;
            ok = 0;
            for (int c = 0; c < 100 && !ok; c++) begin
                @(negedge Clock);
                ok = MemReq && (MemAddr == a);
            end
            if (!ok) fail("fetch_grant_timeout");
            @(posedge Clock); #1;
            if ($urandom_range(0, 1) == 1) IfAddr = $urandom;
            if ($urandom_range(0, 3) == 0) IfReq = 1'b0;
            ok = 0;
            for (int c = 0; c < 100 && !ok; c++) begin
                @(negedge Clock);
                ok = IfValid;
            end
            if (!ok) fail("ifvalid_timeout");
            @(posedge Clock); #1;
        end
        IfReq = 1'b0;
    endtask

    task automatic drive_data(input int n);
        logic [31:0] a;
        bit ok, w;
        for (int i = 0; i < n; i++) begin
            int gap = (i == 0) ? 0 : $urandom_range(0, 2);
            if (gap > 0) begin
                DReq = 1'b0;
                repeat (gap) @(posedge Clock);
                #1;
            end
            a = $urandom; a[31] = 1'b1; a[6] = ($urandom_range(0, 7) == 0);
            w = $urandom_range(0, 1);
            DWData = $urandom; DWidth = 2'($urandom_range(0, 2)); DWrite = w; DAddr = a;
            d_cmd = '{addr: a, write: w, width: DWidth, wdata: DWData};
            exp_d.push_back('{data: (a[6] || w) ? 32'h0 : memfunc(a), err: a[6], store: w});
            DReq = 1'b1; n_issued++;
            ok = 0;
            for (int c = 0; c < 100 && !ok; c++) begin
                @(negedge Clock);
                ok = MemReq && (MemAddr == a);
            end
            if (!ok) fail("data_grant_timeout");
            @(posedge Clock); #1;
            if ($urandom_range(0, 1) == 1) begin
                DAddr = $urandom; DWData = $urandom; DWidth = 2'($urandom_range(0, 3)); DWrite = !w;
            end
            if ($urandom_range(0, 3) == 0) DReq = 1'b0;
            ok = 0;
            for (int c = 0; c < 100 && !ok; c++) begin
                @(negedge Clock);
                ok = DValid;
            end
            if (!ok) fail("dvalid_timeout");
            @(posedge Clock); #1;
        end
        DReq = 1'b0;
    endtask

    initial begin : main
        bit ok, fseen, dseen, dfirst;
        repeat (2) @(negedge Clock);
        chk("rst_memreq", MemReq, 0);
        chk("rst_valids", {IfValid, DValid, BusError}, 3'b000);
        chk("rst_cmd", {MemWrite, MemWidth, MemAddr, MemWData}, 67'h0);
        chk("rst_data", {IfData, DRData}, 64'h0);
        @(posedge Clock); #1;
        Reset = 1'b0;

        fork
            drive_fetch(40);
            drive_data(40);
        join

        // Fetch at 0x100 acked three cycles after MemReq with a fixed word.
        repeat (3) @(posedge Clock);
        #1;
        force_on = 1'b1; force_delay = 3; force_rdata = 32'hDEADBEEF;
        f_cmd = '{addr: 32'h100, write: 1'b0, width: 2'b10, wdata: 32'h0};
        exp_if.push_back('{data: 32'hDEADBEEF, err: 1'b0, store: 1'b0});
        IfAddr = 32'h100; IfReq = 1'b1; n_issued++;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge Clock);
            ok = IfValid;
        end
        if (!ok) fail("example_fetch_timeout");
        @(posedge Clock); #1;
        IfReq = 1'b0; force_on = 1'b0;

        // Reset two cycles into a fetch, with a load waiting behind it.
        repeat (3) @(posedge Clock);
        #1;
        f_cmd = '{addr: 32'h30, write: 1'b0, width: 2'b10, wdata: 32'h0};
        IfAddr = 32'h30; IfReq = 1'b1; n_issued++;
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge Clock);
            ok = MemReq;
        end
        if (!ok) fail("reset_fetch_grant_timeout");
        repeat (2) @(posedge Clock);
        #1;
        d_cmd = '{addr: 32'h8000_0010, write: 1'b0, width: 2'b10, wdata: 32'h0};
        DAddr = 32'h8000_0010; DWrite = 1'b0; DWidth = 2'b10; DWData = 32'h0; DReq = 1'b1;
        Reset = 1'b1;
        #1;
        chk("reset_drops_memreq", MemReq, 0);
        repeat (2) begin
            @(negedge Clock);
            chk("reset_no_valid", {IfValid, DValid}, 2'b00);
        end
        exp_d.push_back('{data: memfunc(32'h8000_0010), err: 1'b0, store: 1'b0});
        exp_if.push_back('{data: memfunc(32'h30), err: 1'b0, store: 1'b0});
        n_issued += 2;
        @(posedge Clock); #1;
        Reset = 1'b0;
        fseen = 0; dseen = 0; dfirst = 0;
        for (int c = 0; c < 60 && !(fseen && dseen); c++) begin
            @(negedge Clock);
            if (DValid) begin dseen = 1; dfirst = !fseen; end
            if (IfValid) fseen = 1;
            @(posedge Clock); #1;
            if (dseen) DReq = 1'b0;
            if (fseen) IfReq = 1'b0;
        end
        if (!(fseen && dseen)) fail("post_reset_timeout");
        chk("post_reset_data_first", dfirst, 1);

        repeat (5) @(posedge Clock);
        #1;
        chk("one_burst_per_request", mem_bursts, n_issued);
        chk("if_queue_drained", exp_if.size(), 0);
        chk("d_queue_drained", exp_d.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
